imsic_setip_merge: RTL and testbench

IMSIC_SETIP_MERGE -- requirements
Module: imsic_setip_merge

---
 rtl/imsic_setip_merge.sv | 130 +++++++++++++
 tb/tb_imsic_setip_merge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imsic_setip_merge.sv
// Buffers MSI setipnum messages and merges them with software writes into the per-file eip registers.
// Build option: define IMSIC_SETIP_DROP_CNT_EN to count discarded messages on o_drop_cnt.
module imsic_setip_merge #(
    parameter int unsigned NR_INTP_FILES   = 7,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned NR_SRC_WIDTH    = 8,
    parameter int unsigned NR_REG          = 1,
    parameter int unsigned INTP_FILE_WIDTH = 3,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_setipnum_vld,
    output logic                                       o_setipnum_rdy,
    input  logic [NR_SRC_WIDTH-1:0]                    i_setipnum,
    input  logic [INTP_FILE_WIDTH-1:0]                 i_setipnum_file,
    input  logic [NR_INTP_FILES*NR_REG-1:0][XLEN-1:0]  eip_sw,
    input  logic [NR_INTP_FILES*NR_REG-1:0]            eip_sw_wr,
    output logic [NR_INTP_FILES*NR_REG-1:0][XLEN-1:0]  eip_final,
    output logic [15:0]                                o_drop_cnt
);

    localparam int unsigned NR_REGS  = NR_INTP_FILES * NR_REG;
    localparam int unsigned ID_SPACE = NR_REG * XLEN;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [INTP_FILE_WIDTH-1:0] file;
        logic [NR_SRC_WIDTH-1:0]    id;
    } setip_ent_t;

    setip_ent_t                        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                  wr_ptr;
    logic [PTR_W-1:0]                  rd_ptr;
    logic [CNT_W-1:0]                  occ;
    logic [CNT_W-1:0]                  occ_nxt;
    logic                              push;
    logic                              pop;
    setip_ent_t                        head;
    logic                              ent_ok;
    int unsigned                       tgt_reg;
    int unsigned                       tgt_bit;
    logic [NR_REGS-1:0][XLEN-1:0]      eip_nxt;

    // Handshake and occupancy update; pop is unconditional whenever something is queued
    always_comb begin
        push    = i_setipnum_vld & o_setipnum_rdy;
        pop     = (occ != '0);
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + CNT_W'(1);
            2'b01:   occ_nxt = occ - CNT_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            o_setipnum_rdy <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ            <= occ_nxt;
            o_setipnum_rdy <= (occ_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // Payload storage needs no reset: pointers and occupancy gate every read
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr] <= '{file: i_setipnum_file, id: i_setipnum};
        end
    end

    // Decode the head entry into a register index and bit position
    always_comb begin
        head    = fifo_mem[rd_ptr];
        tgt_reg = 32'(head.file) * NR_REG + 32'(head.id) / XLEN;
        tgt_bit = 32'(head.id) % XLEN;
        ent_ok  = (32'(head.file) < NR_INTP_FILES) &&
                  (head.id != '0) &&
                  (32'(head.id) < ID_SPACE);
    end

    // Software write replaces the register, then the popped message ORs its bit on top
    always_comb begin
        eip_nxt = eip_final;
        for (int unsigned r = 0; r < NR_REGS; r++) begin
            if (eip_sw_wr[r]) begin
                eip_nxt[r] = eip_sw[r];
            end
            if (pop && ent_ok && (tgt_reg == r)) begin
                eip_nxt[r] = eip_nxt[r] | (XLEN'(1) << tgt_bit);
            end
            if ((r % NR_REG) == 0) begin
                eip_nxt[r][0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eip_final <= '0;
        end else begin
            eip_final <= eip_nxt;
        end
    end

`ifdef IMSIC_SETIP_DROP_CNT_EN
    // Saturating count of popped entries that could not be applied
    always_ff @(posedge clk) begin
        if (rst) begin
            o_drop_cnt <= '0;
        end else if (pop && !ent_ok && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_imsic_setip_merge.sv
// Randomised and directed bench for imsic_setip_merge against a queue-based reference model.
module tb_imsic_setip_merge;

    localparam int unsigned NF    = 7;
    localparam int unsigned XL    = 64;
    localparam int unsigned NS    = 8;
    localparam int unsigned NR    = 1;
    localparam int unsigned FW    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NREGS = NF * NR;
    localparam int unsigned CW    = NREGS * XL;
`ifdef IMSIC_SETIP_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP3 = 16'd3;
`else
    localparam logic [15:0] EXP_DROP3 = 16'd0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          vld;
    logic                          rdy;
    logic [NS-1:0]                 id;
    logic [FW-1:0]                 file;
    logic [NREGS-1:0][XL-1:0]      sw;
    logic [NREGS-1:0]              sw_wr;
    logic [NREGS-1:0][XL-1:0]      eip;
    logic [15:0]                   drop;

    always #5 clk = ~clk;

    imsic_setip_merge #(
        .NR_INTP_FILES(NF), .XLEN(XL), .NR_SRC_WIDTH(NS),
        .NR_REG(NR), .INTP_FILE_WIDTH(FW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .i_setipnum_vld(vld), .o_setipnum_rdy(rdy),
        .i_setipnum(id), .i_setipnum_file(file),
        .eip_sw(sw), .eip_sw_wr(sw_wr),
        .eip_final(eip), .o_drop_cnt(drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [FW+NS-1:0]          q [$];
    logic [NREGS-1:0][XL-1:0]  m_eip;
    logic [15:0]               m_drop;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: the model pops the head queued before the edge, then takes the new message
    task automatic step();
        bit                        acc;
        bit                        do_pop;
        logic [FW+NS-1:0]          hd;
        logic [NREGS-1:0][XL-1:0]  nxt;
        int                        f;
        int                        i;
        acc    = (vld === 1'b1) && (q.size() < DEPTH);
        do_pop = (q.size() != 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_eip  = '0;
            m_drop = '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                nxt[r] = sw_wr[r] ? sw[r] : m_eip[r];
            end
            if (do_pop) begin
                hd = q.pop_front();
                f  = int'(hd[FW+NS-1:NS]);
                i  = int'(hd[NS-1:0]);
                if (f < NF && i != 0 && i < NR * XL) begin
                    nxt[f * NR + i / XL][i % XL] = 1'b1;
                end else begin
`ifdef IMSIC_SETIP_DROP_CNT_EN
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
`endif
                end
            end
            for (int r = 0; r < NREGS; r++) begin
                if (r % NR == 0) nxt[r][0] = 1'b0;
            end
            m_eip = nxt;
            if (acc) q.push_back({file, id});
        end
        #1;
        check("rdy", CW'(rdy), CW'(q.size() < DEPTH));
        check("eip_final", CW'(eip), CW'(m_eip));
        check("drop_cnt", CW'(drop), CW'(m_drop));
    endtask

    task automatic send(input int f, input int i);
        vld  = 1'b1;
        file = FW'(f);
        id   = NS'(i);
        step();
    endtask

    task automatic idle(input int n);
        vld   = 1'b0;
        sw_wr = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        vld   = 1'b0;
        sw_wr = '0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        vld   = 1'b0;
        id    = '0;
        file  = '0;
        sw    = '0;
        sw_wr = '0;
        m_eip = '0;
        m_drop = '0;
        do_reset();
        do_reset();
        idle(3);

        // Single message latency: set visible two edges after acceptance, not one
        send(1, 5);
        vld = 1'b0;
        check("single_not_early", CW'(eip[1]), CW'(64'h0));
        step();
        check("single_visible", CW'(eip[1]), CW'(64'h20));
        check("single_others", CW'(eip[0] | eip[2] | eip[6]), CW'(64'h0));

        // Back-to-back burst lands in order without loss
        do_reset();
        for (int k = 1; k <= 5; k++) send(3, k);
        idle(2);
        check("burst_all", CW'(eip[3]), CW'(64'h3E));

        // Message set beats a simultaneous software clear
        send(0, 3);
        send(0, 7);
        vld      = 1'b0;
        sw_wr[0] = 1'b1;
        sw[0]    = '0;
        step();
        check("collision", CW'(eip[0]), CW'(64'h80));
        idle(1);

        // Invalid identities and files are dropped
        do_reset();
        send(0, 0);
        send(7, 3);
        send(0, 64);
        idle(2);
        check("invalid_eip", CW'(eip), CW'(0));
        check("invalid_drop", CW'(drop), CW'(EXP_DROP3));

        // Software write cannot set bit 0 of a file's first register
        sw_wr[2] = 1'b1;
        sw[2]    = 64'h1;
        step();
        check("sw_bit0", CW'(eip[2]), CW'(64'h0));
        sw[2] = 64'h8000_0000_0000_0003;
        step();
        check("sw_write", CW'(eip[2]), CW'(64'h8000_0000_0000_0002));
        idle(1);

        // Reset mid-stream discards in-flight messages
        send(4, 9);
        send(5, 10);
        send(6, 11);
        rst = 1'b1;
        send(2, 12);
        rst = 1'b0;
        check("rst_eip", CW'(eip), CW'(0));
        check("rst_rdy", CW'(rdy), CW'(1));
        idle(3);
        check("rst_no_stale", CW'(eip), CW'(0));

        // Randomised traffic with software writes and occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            vld  = ($urandom_range(0, 2) != 0);
            file = FW'($urandom_range(0, 7));
            id   = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(0, 255))
                                               : NS'($urandom_range(0, 70));
            for (int r = 0; r < NREGS; r++) begin
                sw_wr[r] = ($urandom_range(0, 15) == 0);
                sw[r]    = {$urandom, $urandom};
            end
            step();
        end
        rst = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
